// File: rtl/dsp48a1_dot_seq_pkg.sv
// rtl/dsp48a1_dot_seq_pkg.sv - shared constants and types for the DSP48A1 dot-product sequencer
package dsp48a1_dot_seq_pkg;

    localparam int OPND_W = 18;
    localparam int P_W    = 48;
    localparam int OPM_W  = 8;

    // X=M, Z=0 starts a new sum; X=M, Z=P accumulates onto it
    localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;
    localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;
    localparam logic [OPM_W-1:0] OPM_IDLE  = OPM_ACC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dsp48a1_dot_seq_opmode_delay.sv
// rtl/dsp48a1_dot_seq_opmode_delay.sv - OPMODE shift register aligning opcodes with the slice A1/B1 stage
module opmode_delay
    import dsp48a1_dot_seq_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPM_W-1:0] din,
    output logic [OPM_W-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DELAY-1:0][OPM_W-1:0] sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DELAY; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/dsp48a1_dot_seq.sv
// rtl/dsp48a1_dot_seq.sv - streams operand pairs into a DSP48A1 MAC slice and returns the accumulated P
module dsp48a1_dot_seq
    import dsp48a1_dot_seq_pkg::*;
#(
    parameter int LAT          = 3,
    parameter int OPMODE_DELAY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OPND_W-1:0] s_a,
    input  logic [OPND_W-1:0] s_b,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [P_W-1:0]    m_result,
    output logic [CNT_W-1:0]  m_count,
    output logic [OPND_W-1:0] dsp_a,
    output logic [OPND_W-1:0] dsp_b,
    output logic [OPM_W-1:0]  dsp_opmode,
    input  logic [P_W-1:0]    dsp_p
);

    localparam int DCNT_W = $clog2(LAT + 2);
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(LAT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DCNT_W-1:0]  drain_q, drain_d;
    logic               s_ready_q;
    logic               m_valid_q;
    logic [P_W-1:0]     m_result_q;
    logic [CNT_W-1:0]   m_count_q;
    logic [OPND_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OPM_W-1:0]   opm_q, opm_d;

    logic fire, buf_free, capture;

    assign fire     = s_valid & s_ready_q;
    assign buf_free = !m_valid_q || m_ready;
    // Counter value 1 means it hits 0 on this edge, so P already holds the last product
    assign capture  = (state_q == DRAIN) && (drain_q <= DCNT_W'(1)) && buf_free;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        a_d     = '0;
        b_d     = '0;
        opm_d   = OPM_IDLE;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    a_d   = s_a;
                    b_d   = s_b;
                    opm_d = OPM_FIRST;
                    cnt_d = CNT_W'(1);
                    if (s_last) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (fire) begin
                    a_d   = s_a;
                    b_d   = s_b;
                    opm_d = OPM_ACC;
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    if (s_last) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - DCNT_W'(1);
                end
                if (capture) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            drain_q   <= '0;
            s_ready_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            opm_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            s_ready_q <= (state_d != DRAIN);
            a_q       <= a_d;
            b_q       <= b_d;
            opm_q     <= opm_d;
        end
    end

    // Single-entry result buffer; a capture on a draining edge overwrites in place
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid_q  <= 1'b0;
            m_result_q <= '0;
            m_count_q  <= '0;
        end else if (capture) begin
            m_valid_q  <= 1'b1;
            m_result_q <= dsp_p;
            m_count_q  <= cnt_q;
        end else if (m_ready) begin
            m_valid_q  <= 1'b0;
        end
    end

    opmode_delay #(
        .DELAY (OPMODE_DELAY)
    ) u_opmode_delay (
        .clk  (CLK),
        .rst  (RST),
        .din  (opm_q),
        .dout (dsp_opmode)
    );

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_result = m_result_q;
    assign m_count  = m_count_q;
    assign dsp_a    = a_q;
    assign dsp_b    = b_q;

endmodule

// File: tb/tb_dsp48a1_dot_seq.sv
// tb/tb_dsp48a1_dot_seq.sv - sequencer plus behavioural DSP48A1 slice with a dot-product scoreboard
module tb_dsp48a1_dot_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] s_a = '0;
    logic [17:0] s_b = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [47:0] m_result;
    logic [15:0] m_count;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;

    always #5 clk = ~clk;

    dsp48a1_dot_seq #(
        .LAT          (3),
        .OPMODE_DELAY (1),
        .CNT_W        (16)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_result   (m_result),
        .m_count    (m_count),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_p      (dsp_p)
    );

    // Slice: A1REG/B1REG, MREG, OPMODEREG, PREG; CE high, RST low
    logic [17:0] sl_a1 = '0, sl_b1 = '0;
    logic [35:0] sl_m = '0;
    logic [7:0]  sl_opm = '0;
    logic [47:0] sl_p = '0;
    logic [47:0] sl_x, sl_z;

    always_comb begin
        sl_x = (sl_opm[1:0] == 2'b01) ? {12'b0, sl_m} : 48'b0;
        sl_z = (sl_opm[3:2] == 2'b10) ? sl_p : 48'b0;
    end

    always @(posedge clk) begin
        sl_a1  <= dsp_a;
        sl_b1  <= dsp_b;
        sl_m   <= 36'(sl_a1) * 36'(sl_b1);
        sl_opm <= dsp_opmode;
        sl_p   <= sl_x + sl_z;
    end
    assign dsp_p = sl_p;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [47:0] mdl_acc = '0;
    int          mdl_cnt = 0;
    logic [47:0] exp_r[$];
    logic [15:0] exp_c[$];
    logic [47:0] pop_r;
    logic [15:0] pop_c;

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_cmp++;
            if (exp_r.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got result=%0h count=%0d, required no output", m_result, m_count);
            end else begin
                pop_r = exp_r.pop_front();
                pop_c = exp_c.pop_front();
                if (m_result !== pop_r || m_count !== pop_c) begin
                    n_bad++;
                    $display("FAIL sb_result: got result=%0h count=%0d, required result=%0h count=%0d",
                             m_result, m_count, pop_r, pop_c);
                end
            end
        end
    end

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_last = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: s_ready=%0b, required 1 within 200 cycles", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        s_last = 1'b0;
        if (ok) begin
            mdl_acc = mdl_acc + 48'(a) * 48'(b);
            if (mdl_cnt < 65535) mdl_cnt++;
            if (last) begin
                exp_r.push_back(mdl_acc);
                exp_c.push_back(16'(mdl_cnt));
                mdl_acc = '0;
                mdl_cnt = 0;
            end
        end
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 300 && exp_r.size() != 0; k++) @(negedge clk);
        n_cmp++;
        if (exp_r.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d, required 0", exp_r.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || dsp_a !== 18'd0 || dsp_b !== 18'd0 || dsp_opmode !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: s_ready=%0b m_valid=%0b a=%0h b=%0h opm=%0h, required all 0",
                     s_ready, m_valid, dsp_a, dsp_b, dsp_opmode);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_early: s_ready=%0b, required 0", s_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_after_edge: s_ready=%0b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        lat = -1;
        send_pair(18'd2, 18'd3, 1'b0);
        send_pair(18'd4, 18'd5, 1'b0);
        send_pair(18'd6, 18'd7, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_valid) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat != 4) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d cycles, required 4", lat);
        end
        wait_empty();
    endtask

    task automatic test_single();
        send_pair(18'd100, 18'd200, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (dsp_a !== 18'd100 || dsp_b !== 18'd200 || dsp_opmode !== 8'h09) begin
            n_bad++;
            $display("FAIL single_issue: a=%0d b=%0d opm=%0h, required a=100 b=200 opm=09", dsp_a, dsp_b, dsp_opmode);
        end
        @(negedge clk);
        n_cmp++;
        if (dsp_opmode !== 8'h01 || dsp_a !== 18'd0 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_opmode: opm=%0h a=%0d s_ready=%0b, required opm=01 a=0 s_ready=0",
                     dsp_opmode, dsp_a, s_ready);
        end
        wait_empty();
    endtask

    task automatic test_gaps();
        send_pair(18'd2, 18'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send_pair(18'd4, 18'd5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send_pair(18'd6, 18'd7, 1'b1);
        wait_empty();
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_pair(18'd2, 18'd3, 1'b0);
        send_pair(18'd4, 18'd5, 1'b0);
        send_pair(18'd6, 18'd7, 1'b1);
        send_pair(18'd1, 18'd1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_result !== 48'd68) begin
                n_bad++;
                $display("FAIL bp_hold: s_ready=%0b m_valid=%0b result=%0d, required 0 1 68",
                         s_ready, m_valid, m_result);
            end
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_empty();
    endtask

    task automatic test_mid_reset();
        send_pair(18'd9, 18'd9, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || dsp_a !== 18'd0 || dsp_b !== 18'd0 || dsp_opmode !== 8'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: s_ready=%0b m_valid=%0b a=%0h b=%0h opm=%0h, required all 0",
                     s_ready, m_valid, dsp_a, dsp_b, dsp_opmode);
        end
        mdl_acc = '0;
        mdl_cnt = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        send_pair(18'd3, 18'd3, 1'b1);
        wait_empty();
    endtask

    task automatic test_max_operands();
        for (int i = 0; i < 4; i++) begin
            send_pair(18'h3FFFF, 18'h3FFFF, (i == 3));
        end
        n_cmp++;
        if (exp_r.size() != 1 || exp_r[0] !== 48'h3F_FFE0_0004 || exp_c[0] !== 16'd4) begin
            n_bad++;
            $display("FAIL max_model: pending=%0d, required one entry 3fffe00004/4", exp_r.size());
        end
        wait_empty();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_gaps();
        test_backpressure();
        test_mid_reset();
        test_max_operands();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
